one_bit_4_1_tdm_mux: RTL

ONE_BIT_4_1_TDM_MUX -- requirements
Module: one_bit_4_1_tdm_mux

---
 rtl/one_bit_4_1_tdm_mux.sv | 100 ++++++++++
 1 files changed

// File: rtl/one_bit_4_1_tdm_mux.sv
// Four-channel round-robin time-division multiplexer with valid/ready handshakes.
// Each output word is tagged with its source code {out_s1,out_s0} so a downstream demux can route it back.
module one_bit_4_1_tdm_mux #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in1_data,
  input  logic [WIDTH-1:0] in2_data,
  input  logic [WIDTH-1:0] in3_data,
  input  logic [WIDTH-1:0] in4_data,
  input  logic             in1_valid,
  input  logic             in2_valid,
  input  logic             in3_valid,
  input  logic             in4_valid,
  output logic             in1_ready,
  output logic             in2_ready,
  output logic             in3_ready,
  output logic             in4_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_s0,
  output logic             out_s1
);

  logic [1:0]       ptr_r;
  logic [1:0]       code_r;
  logic [WIDTH-1:0] data_r;
  logic             valid_r;

  logic [3:0]       valid_vec_s;
  logic [3:0]       ready_s;
  logic [1:0]       grant_s;
  logic [WIDTH-1:0] grant_data_s;
  logic             load_en_s;
  logic             load_s;

  // First valid channel at or after the priority pointer, wrapping modulo 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] v, input logic [1:0] p);
    logic [1:0] idx;
    rr_pick = p;
    for (int i = 3; i >= 0; i--) begin
      idx     = p + 2'(i);
      rr_pick = v[idx] ? idx : rr_pick;
    end
  endfunction

  // Arbitration, handshake generation and payload selection.
  always_comb begin
    valid_vec_s  = {in4_valid, in3_valid, in2_valid, in1_valid};
    load_en_s    = !valid_r || out_ready;
    grant_s      = rr_pick(valid_vec_s, ptr_r);
    load_s       = load_en_s && (|valid_vec_s) && !reset;
    ready_s      = 4'b0000;
    grant_data_s = {WIDTH{1'b0}};
    if (load_s) begin
      ready_s = 4'b0001 << grant_s;
    end else begin
      ready_s = 4'b0000;
    end
    case (grant_s)
      2'b00:   grant_data_s = in1_data;
      2'b01:   grant_data_s = in2_data;
      2'b10:   grant_data_s = in3_data;
      2'b11:   grant_data_s = in4_data;
      default: grant_data_s = {WIDTH{1'b0}};
    endcase
  end

  assign in1_ready = ready_s[0];
  assign in2_ready = ready_s[1];
  assign in3_ready = ready_s[2];
  assign in4_ready = ready_s[3];

  // Output register and pointer; a drain with no new grant only clears valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r <= 1'b0;
      data_r  <= {WIDTH{1'b0}};
      code_r  <= 2'b00;
      ptr_r   <= 2'b00;
    end else if (load_s) begin
      valid_r <= 1'b1;
      data_r  <= grant_data_s;
      code_r  <= grant_s;
      ptr_r   <= grant_s + 2'b01;
    end else if (valid_r && out_ready) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign out_valid = valid_r;
  assign out_data  = data_r;
  assign out_s0    = code_r[0];
  assign out_s1    = code_r[1];

endmodule
